// File: rtl/riscv_data_mem.sv
// RV32I data memory: combinational read, byte-lane synchronous write, async clear.
// Define DATA_MEM_ASSERT_EN to compile in simulation-only misuse checks.
module riscv_data_mem #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      wr_sel,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wr_data,
   output logic [XLEN-1:0] rd_data
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [AW-1:0]   word_idx;
   logic            in_range;
   logic [XLEN-1:0] word_d;

   assign word_idx = addr[AW+1:2];
   // Upper bits must all be zero: an out-of-range address never aliases a real word.
   assign in_range = (addr[XLEN-1:AW+2] == '0);
   assign rd_data  = in_range ? mem_q[word_idx] : '0;

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      word_d = mem_q[word_idx];
      for (int lane = 0; lane < 4; lane++) begin
         if (wr_sel[lane]) begin
            word_d[8*lane +: 8] = wr_data[8*lane +: 8];
         end
      end
   end

   // NOTE: this memory is deliberately reset as a whole because reads must see zero
   // immediately after reset; that keeps it out of block RAM, which is acceptable here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            // NOTE: sequential state is only ever updated with non-blocking assignments.
            mem_q[i] <= '0;
         end
      end else if (in_range && (wr_sel != 4'b0000)) begin
         mem_q[word_idx] <= word_d;
      end
   end

`ifdef DATA_MEM_ASSERT_EN
   always @(posedge clk) begin
      if (!rst) begin
         if ($isunknown(wr_sel)) begin
            $error("riscv_data_mem: wr_sel contains X/Z (%b)", wr_sel);
         end else begin
            if ((wr_sel != 4'b0000) && !in_range) begin
               $error("riscv_data_mem: write to out-of-range addr 0x%08h", addr);
            end
            if ((wr_sel == 4'b1111) && (addr[1:0] != 2'b00)) begin
               $error("riscv_data_mem: misaligned word store at 0x%08h", addr);
            end
            if (((wr_sel == 4'b0011) || (wr_sel == 4'b1100)) && addr[0]) begin
               $error("riscv_data_mem: misaligned half store at 0x%08h", addr);
            end
         end
      end
   end
`else
   // Checks compiled out; the design is purely synthesizable.
`endif

endmodule

// File: tb/tb_riscv_data_mem.sv
// Self-checking bench for riscv_data_mem: directed cases plus randomized traffic
// compared against a word-array reference model.
module tb_riscv_data_mem;

   localparam int unsigned DEPTH = 256;

   logic        clk;
   logic        rst;
   logic [3:0]  wr_sel;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [31:0] model [DEPTH];

   riscv_data_mem #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_sel  (wr_sel),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      if (a >= DEPTH * 4) return 32'h0;
      return model[a / 4];
   endfunction

   function automatic void model_wr(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] d);
      if (a >= DEPTH * 4) return;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) model[a / 4][8*b +: 8] = d[8*b +: 8];
      end
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
   endfunction

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic do_write(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] d);
      wr_sel  = sel;
      addr    = a;
      wr_data = d;
      @(posedge clk);
      model_wr(sel, a, d);
      @(negedge clk);
      wr_sel  = 4'b0000;
      wr_data = 32'h0;
   endtask

   task automatic check_rd(input string tag, input logic [31:0] a);
      addr = a;
      #1;
      check(tag, rd_data, model_rd(a));
   endtask

   initial begin
      logic [3:0]  r_sel;
      logic [31:0] r_addr;
      logic [31:0] r_data;

      rst     = 1'b1;
      wr_sel  = 4'b0000;
      addr    = 32'h0;
      wr_data = 32'h0;
      model_clear();

      @(negedge clk);
      check_rd("reset_rd_0x000", 32'h000);
      check_rd("reset_rd_0x3fc", 32'h3FC);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset clears memory without a clock edge.
      do_write(4'b1111, 32'h10, 32'hDEADBEEF);
      check_rd("preload_0x10", 32'h10);
      @(posedge clk);
      #2 rst = 1'b1;
      model_clear();
      #1 check("async_clear_during_rst", rd_data, 32'h0);
      #1 rst = 1'b0;
      #1 check("async_clear_after_rst", rd_data, 32'h0);
      @(negedge clk);

      // A write presented while rst=1 is discarded.
      rst = 1'b1;
      wr_sel = 4'b1111; addr = 32'h14; wr_data = 32'h5A5A5A5A;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; wr_sel = 4'b0000;
      check_rd("write_under_rst_dropped", 32'h14);

      // Full-word write and neighbours untouched.
      do_write(4'b1111, 32'h04, 32'h12345678);
      check("sw_0x04", model_rd(32'h04), 32'h12345678);
      check_rd("sw_rd_0x04", 32'h04);
      check_rd("sw_neigh_0x00", 32'h00);
      check_rd("sw_neigh_0x08", 32'h08);

      // Byte-lane merge.
      do_write(4'b1111, 32'h20, 32'hAABBCCDD);
      do_write(4'b0100, 32'h20, 32'h00EE0000);
      addr = 32'h20; #1 check("sb_merge", rd_data, 32'hAAEECCDD);
      do_write(4'b0011, 32'h20, 32'h00001122);
      addr = 32'h20; #1 check("sh_merge", rd_data, 32'hAAEE1122);

      // No write, ignored low address bits.
      do_write(4'b0000, 32'h20, 32'hFFFFFFFF);
      addr = 32'h20; #1 check("no_write", rd_data, 32'hAAEE1122);
      addr = 32'h23; #1 check("low_bits_ignored", rd_data, 32'hAAEE1122);

      // Read during write: old word before the edge, new word right after it.
      do_write(4'b1111, 32'h30, 32'h1);
      wr_sel = 4'b1111; addr = 32'h30; wr_data = 32'h2;
      #1 check("rdw_before_edge", rd_data, 32'h1);
      @(posedge clk);
      model_wr(4'b1111, 32'h30, 32'h2);
      #3 check("rdw_after_edge", rd_data, 32'h2);
      @(negedge clk);
      wr_sel = 4'b0000;

      // Out of range: read zero, write ignored, no aliasing.
      do_write(4'b1111, 32'h400, 32'hCAFEF00D);
      addr = 32'h400; #1 check("oor_rd_0x400", rd_data, 32'h0);
      addr = 32'h000; #1 check("oor_no_alias_0x000", rd_data, 32'h0);
      do_write(4'b1111, 32'h8000_0020, 32'h0BADF00D);
      addr = 32'h20; #1 check("oor_high_no_alias", rd_data, 32'hAAEE1122);
      check_rd("last_word_0x3fc", 32'h3FC);
      do_write(4'b1111, 32'h3FC, 32'h7E57C0DE);
      addr = 32'h3FC; #1 check("last_word_write", rd_data, 32'h7E57C0DE);

      // Randomized traffic against the model.
      for (int it = 0; it < 400; it++) begin
         r_sel  = 4'($urandom_range(0, 15));
         r_data = $urandom;
         case ($urandom_range(0, 9))
            0:       r_addr = $urandom;
            1:       r_addr = 32'h400 + 32'($urandom_range(0, 4095));
            default: r_addr = 32'($urandom_range(0, DEPTH * 4 - 1));
         endcase
         if ($urandom_range(0, 49) == 0) begin
            #1 rst = 1'b1;
            model_clear();
            #1 rst = 1'b0;
         end
         do_write(r_sel, r_addr, r_data);
         check_rd($sformatf("rnd%0d_same", it), r_addr);
         check_rd($sformatf("rnd%0d_other", it), 32'($urandom_range(0, DEPTH * 4 + 63)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
